// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for an 8-bit synchronous FIFO.
// Pops the FIFO while there is guaranteed buffer room, captures the registered
// FIFO output one cycle after each pop, and streams bytes out on valid/ready.
module fifo_reader #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned BUF_DEPTH = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic             fifo_underflow,
   input  logic [WIDTH-1:0] fifo_out,
   output logic             fifo_rd_en,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             err
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [OCC_W:0] DEPTH_CMP = BUF_DEPTH[OCC_W:0];

   // Control state is implied by (inflight, occ); this is a decoded view of it.
   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

   logic [WIDTH-1:0] buf_mem [BUF_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [OCC_W-1:0] occ;
   logic             inflight;
   logic [OCC_W:0]   pending;
   logic             capture;
   logic             deliver;
   state_t           state;

   // Slots already committed: buffered bytes plus the one still on the FIFO output.
   assign pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};

   // Pop only when a slot is guaranteed for the byte, so the buffer never overruns.
   assign fifo_rd_en = enable && !fifo_empty && !reset && (pending < DEPTH_CMP);

   assign capture = inflight;
   assign deliver = m_valid && m_ready;

   assign m_valid = (occ != '0);
   assign m_data  = buf_mem[rd_ptr];
   assign busy    = (state != StIdle);

   // Decode control state from the registered occupancy and in-flight flag.
   always_comb begin
      state = StIdle;
      if (inflight || (occ != '0)) begin
         state = enable ? StRun : StDrain;
      end
   end

   // Buffer storage: the byte popped last cycle lands at the write pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            buf_mem[i] <= '0;
         end
      end else if (capture) begin
         buf_mem[wr_ptr] <= fifo_out;
      end
   end

   // Pointers, occupancy and in-flight tracking; capture and delivery may coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         if (capture) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (deliver) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         occ <= occ + {{PTR_W{1'b0}}, capture} - {{PTR_W{1'b0}}, deliver};
      end
   end

   // Delivered-byte counter, wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (deliver) begin
         count <= count + CNT_W'(1);
      end
   end

   // Sticky error: FIFO underflow or a pop request against an empty FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else if (fifo_underflow || (fifo_rd_en && fifo_empty)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Testbench for fifo_reader: behavioural FIFO model, a table of cycle vectors
// for the basic stream, and directed sequences for the multi-cycle cases.
module tb_fifo_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        fifo_empty;
   logic        fifo_underflow = 1'b0;
   logic [7:0]  fifo_out;
   logic        fifo_rd_en;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        busy;
   logic [15:0] count;
   logic        err;

   // Second instance with a narrow counter to exercise wrap-around.
   logic        w_reset = 1'b1;
   logic        w_rd_en;
   logic [7:0]  w_data;
   logic        w_valid;
   logic        w_busy;
   logic [3:0]  w_count;
   logic        w_err;

   int n_checks = 0;
   int n_fail = 0;
   int rd_pulses = 0;
   logic [7:0] got[$];

   // FIFO model
   logic       wr = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic [7:0] fmem [256];
   logic [7:0] fwp;
   logic [7:0] frp;
   int         fcnt;

   always #5 clk = ~clk;

   fifo_reader #(.WIDTH(8), .BUF_DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_underflow(fifo_underflow), .fifo_out(fifo_out), .fifo_rd_en(fifo_rd_en),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
      .count(count), .err(err)
   );

   fifo_reader #(.WIDTH(8), .BUF_DEPTH(4), .CNT_W(4)) dut_wrap (
      .clk(clk), .reset(w_reset), .enable(1'b1), .fifo_empty(1'b0),
      .fifo_underflow(1'b0), .fifo_out(8'hA5), .fifo_rd_en(w_rd_en),
      .m_data(w_data), .m_valid(w_valid), .m_ready(1'b1), .busy(w_busy),
      .count(w_count), .err(w_err)
   );

   assign fifo_empty = (fcnt == 0);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         fwp <= 8'd0;
         frp <= 8'd0;
         fcnt <= 0;
         fifo_out <= 8'd0;
      end else begin
         if (fifo_rd_en && fcnt != 0) begin
            fifo_out <= fmem[frp];
            frp <= frp + 8'd1;
         end
         if (wr) begin
            fmem[fwp] <= wdata;
            fwp <= fwp + 8'd1;
         end
         fcnt <= fcnt + (wr ? 1 : 0) - ((fifo_rd_en && fcnt != 0) ? 1 : 0);
      end
   end

   // Stream monitor
   always @(posedge clk) begin
      if (!reset) begin
         if (m_valid && m_ready) got.push_back(m_data);
         if (fifo_rd_en) rd_pulses++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      wr = 1'b0;
      enable = 1'b0;
      m_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      got.delete();
      rd_pulses = 0;
   endtask

   task automatic push_bytes(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wr = 1'b1;
         wdata = base + 8'(i);
      end
      @(negedge clk);
      wr = 1'b0;
   endtask

   typedef struct {
      logic       wr;
      logic [7:0] wd;
      logic       exp_rd;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_busy;
   } vec_t;

   vec_t vecs[9];

   initial begin
      bit done;
      // Basic stream 16..20 with enable=1, m_ready=1; latency 2 after empty falls.
      vecs[0] = '{1'b1, 8'd16, 1'b0, 1'b0, 8'd0,  1'b0};
      vecs[1] = '{1'b1, 8'd17, 1'b1, 1'b0, 8'd0,  1'b0};
      vecs[2] = '{1'b1, 8'd18, 1'b1, 1'b0, 8'd0,  1'b1};
      vecs[3] = '{1'b1, 8'd19, 1'b1, 1'b1, 8'd16, 1'b1};
      vecs[4] = '{1'b1, 8'd20, 1'b1, 1'b1, 8'd17, 1'b1};
      vecs[5] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd18, 1'b1};
      vecs[6] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd19, 1'b1};
      vecs[7] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd20, 1'b1};
      vecs[8] = '{1'b0, 8'd0,  1'b0, 1'b0, 8'd0,  1'b0};

      repeat (2) @(negedge clk);
      #1;
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      check("rst_err", err, 0);
      reset = 1'b0;

      // Test 1: table-driven stream
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         enable = 1'b1;
         m_ready = 1'b1;
         wr = vecs[i].wr;
         wdata = vecs[i].wd;
         #1;
         check($sformatf("t1_rd_en[%0d]", i), fifo_rd_en, vecs[i].exp_rd);
         check($sformatf("t1_valid[%0d]", i), m_valid, vecs[i].exp_valid);
         check($sformatf("t1_busy[%0d]", i), busy, vecs[i].exp_busy);
         if (vecs[i].exp_valid) check($sformatf("t1_data[%0d]", i), m_data, vecs[i].exp_data);
      end
      check("t1_count", count, 5);

      // Test 2: backpressure with 10 bytes queued
      do_reset();
      push_bytes(8'h20, 10);
      rd_pulses = 0;
      enable = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("t2_rd_pulses", rd_pulses, 4);
      check("t2_rd_held", fifo_rd_en, 0);
      check("t2_valid", m_valid, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("t2_stable[%0d]", i), m_data, 8'h20);
      end
      got.delete();
      @(negedge clk);
      m_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("t2_no_gaps", got.size(), 10);
      for (int i = 0; i < got.size(); i++) check($sformatf("t2_order[%0d]", i), got[i], 8'h20 + i);
      #1;
      check("t2_busy_end", busy, 0);
      check("t2_count", count, 10);

      // Test 3: drop enable while a pop is in flight
      do_reset();
      enable = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      wr = 1'b1;
      wdata = 8'h51;
      @(negedge clk);
      wdata = 8'h52;
      #1;
      check("t3_rd_on", fifo_rd_en, 1);
      @(negedge clk);
      wdata = 8'h53;
      enable = 1'b0;
      #1;
      check("t3_rd_off", fifo_rd_en, 0);
      check("t3_busy_drain", busy, 1);
      @(negedge clk);
      wr = 1'b0;
      repeat (8) @(negedge clk);
      check("t3_rd_pulses", rd_pulses, 1);
      check("t3_delivered", got.size(), 1);
      if (got.size() > 0) check("t3_byte", got[0], 8'h51);
      check("t3_busy_end", busy, 0);
      check("t3_fifo_left", fcnt, 2);

      // Test 4: alternate-cycle m_ready with 8 bytes queued
      do_reset();
      push_bytes(8'h60, 8);
      enable = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         m_ready = ~m_ready;
         if (got.size() >= 8) done = 1'b1;
      end
      check("t4_done", done, 1);
      check("t4_size", got.size(), 8);
      for (int i = 0; i < got.size(); i++) check($sformatf("t4_order[%0d]", i), got[i], 8'h60 + i);
      @(negedge clk);
      m_ready = 1'b0;
      check("t4_count", count, 8);

      // Test 5: reset with occ=2 and a pop in flight
      enable = 1'b0;
      push_bytes(8'h70, 6);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("t5_pre_valid", m_valid, 1);
      check("t5_pre_data", m_data, 8'h70);
      check("t5_pre_rd", fifo_rd_en, 1);
      reset = 1'b1;
      #1;
      check("t5_rst_rd_en", fifo_rd_en, 0);
      check("t5_rst_valid", m_valid, 0);
      check("t5_rst_data", m_data, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_count", count, 0);
      @(negedge clk);
      reset = 1'b0;
      got.delete();
      m_ready = 1'b1;
      push_bytes(8'h80, 2);
      repeat (8) @(negedge clk);
      check("t5_fresh_size", got.size(), 2);
      if (got.size() == 2) begin
         check("t5_fresh0", got[0], 8'h80);
         check("t5_fresh1", got[1], 8'h81);
      end
      check("t5_fresh_count", count, 2);

      // Test 6: sticky err, then counter wrap on the narrow instance
      @(negedge clk);
      fifo_underflow = 1'b1;
      @(negedge clk);
      fifo_underflow = 1'b0;
      check("t6_err_set", err, 1);
      push_bytes(8'h90, 3);
      repeat (8) @(negedge clk);
      check("t6_err_sticky", err, 1);
      check("t6_count", count, 5);
      do_reset();
      #1;
      check("t6_err_clear", err, 0);

      w_reset = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (w_count == 4'd15) done = 1'b1;
      end
      check("t6_wrap_reach", done, 1);
      check("t6_wrap_valid", w_valid, 1);
      @(negedge clk);
      check("t6_wrap_zero", w_count, 0);
      check("t6_wrap_data", w_data, 8'hA5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
      $fatal(1);
   end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the 8-bit synchronous FIFO. It watches `empty`, issues single-cycle `rd_en` pops, and captures the registered `out` byte one cycle later into a small internal buffer. It presents each byte on a valid/ready stream to the downstream consumer with no loss or duplication. It sits between the FIFO and any byte consumer (UART TX, packetiser) and is the counterpart of whatever logic drives `wr_en`/`in`.

## Interface

Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- `WIDTH`, 8: data width; must equal the FIFO data width.
- `BUF_DEPTH`, 4: internal buffer entries; power of two, at least 3 (3 or more needed for one byte per cycle).
- `CNT_W`, 16: width of the delivered-byte counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  allow new pops; deasserting does not discard buffered or in-flight bytes.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_underflow`  in  1  FIFO `underflow` flag.
- `fifo_out`  in  WIDTH  FIFO `out`; valid the cycle after a pop edge.
- `fifo_rd_en`  out  1  pop request to FIFO `rd_en`.
- `m_data`  out  WIDTH  head-of-buffer byte.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  consumer accepts when `m_valid && m_ready` at a rising edge.
- `busy`  out  1  a pop is in flight or the buffer is non-empty.
- `count`  out  CNT_W  bytes delivered downstream; wraps modulo 2^CNT_W.
- `err`  out  1  sticky error flag.

## Operation

- Internal state:
  - circular buffer with `BUF_DEPTH` entries, read pointer, write pointer, occupancy `occ` (0..BUF_DEPTH);
  - 1-bit `inflight` register, set on the edge where `fifo_rd_en` is sampled high;
  - `count` and `err` registers.
- Pop request (combinational): `fifo_rd_en = enable && !fifo_empty && !reset && (occ + inflight < BUF_DEPTH)`.
  - `occ` and `inflight` here are the current registered values.
  - The request therefore never overruns the buffer.
- Capture: on each edge where `inflight == 1`, write `fifo_out` at the write pointer.
  - Then update `inflight <= fifo_rd_en` for the current cycle.
- Delivery:
  - `m_valid = (occ != 0)`; `m_data` = entry at the read pointer, driven from registers.
  - On the handshake edge, advance the read pointer and increment `count`.
- Simultaneous capture and handshake in the same edge: `occ` is unchanged and both pointers advance.
- Pointer wrap: pointers are log2(BUF_DEPTH) bits and wrap naturally; ordering is strict FIFO.
- Control states, encoded by (`inflight`, `occ`):
  - IDLE: `inflight = 0`, `occ = 0`;
  - RUN: `enable` = 1 and not IDLE;
  - DRAIN: `enable` = 0 and not IDLE.
  - `busy` = not IDLE.
  - In DRAIN, the in-flight byte is still captured and the buffer still empties through `m_ready`; no new pops are issued.
- `err` sets on any edge where `fifo_underflow` = 1 or `fifo_rd_en && fifo_empty` would occur. It clears only on `reset`.
- Reset mid-operation (any cycle): buffer contents, in-flight byte, and counters are discarded. Bytes already popped from the FIFO are lost by design.
- `m_data` is held stable while `m_valid && !m_ready`.

## Timing

- Reset values:
  - `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0;
  - `busy` = 0, `count` = 0, `err` = 0;
  - `occ` = 0, `inflight` = 0, both pointers 0.
- First-byte latency: `fifo_empty` falls after edge E, so `fifo_rd_en` is high during cycle E.
  - The FIFO pops at edge E+1; the byte is captured at edge E+2.
  - `m_valid` is high after edge E+2, i.e. 2 cycles.
- Throughput: with `BUF_DEPTH` ≥ 3, FIFO non-empty and `m_ready` held 1, there is one pop and one delivery per cycle.
- Backpressure: with `m_ready` = 0, exactly `BUF_DEPTH` bytes are popped, then `fifo_rd_en` stays 0.
- `fifo_rd_en` is never high for two cycles unless a slot is guaranteed for both bytes.

## Test plan

1. Reset, then write 16, 17, 18, 19, 20 into the FIFO with `enable` = 1 and `m_ready` = 1.
   - `m_data` = 16..20 in order on consecutive cycles.
   - First `m_valid` 2 cycles after `empty` falls; `count` = 5; `busy` returns to 0.
2. FIFO holds 10 bytes, `m_ready` = 0.
   - Exactly 4 `fifo_rd_en` pulses, then `occ` = 4 and `m_valid` holds the first byte with stable data.
   - Releasing `m_ready` delivers all 10 in order with no gaps.
3. Drop `enable` while a pop is in flight.
   - The in-flight byte is still delivered; no further `fifo_rd_en`; `busy` falls after the buffer drains.
4. Toggle `m_ready` on alternate cycles with 8 bytes queued.
   - All 8 delivered in order, no duplicates; `count` = 8.
5. Assert `reset` with `occ` = 2 and a pop in flight.
   - All outputs return to reset values immediately; the next stream starts fresh with `count` = 0.
6. Pulse `fifo_underflow` once.
   - `err` = 1 and stays 1 through further traffic until `reset`.
   - Preload `count` to 0xFFFF and deliver one byte: `count` wraps to 0.
